// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage: opcode map, status bit
// positions and the control FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_SUB   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_INC   = 4'd8;
  localparam logic [3:0] OP_DEC   = 4'd9;
  localparam logic [3:0] OP_PASSA = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
  localparam logic [3:0] OP_ZERO  = 4'd12;
  localparam logic [3:0] OP_ALL   = 4'd13;
  localparam logic [3:0] OP_NOP   = 4'd14;
  localparam logic [3:0] OP_ONE   = 4'd15;

  localparam int ST_C = 0;
  localparam int ST_Z = 1;
  localparam int ST_N = 2;
  localparam int ST_V = 3;
  localparam int ST_P = 4;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_EXEC = 2'd1,
    FSM_HOLD = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one writeback port and
// one load port; writeback beats a load to the same entry.
module alu_regfile #(
  parameter int N    = 3,
  parameter int REGS = 4,
  localparam int AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data
);

  logic [N-1:0] rf_q [REGS];

  genvar gi;
  generate
    for (gi = 0; gi < REGS; gi++) begin : g_entry
      logic [N-1:0] q_reg;
      logic         wb_hit;
      logic         ld_hit;

      assign wb_hit = wb_en && (wb_addr == AW'(gi));
      assign ld_hit = ld_en && (ld_addr == AW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (wb_hit) begin
          q_reg <= wb_data;
        end else if (ld_hit) begin
          q_reg <= ld_data;
        end
      end

      assign rf_q[gi] = q_reg;
    end
  endgenerate

  assign rd1 = rf_q[ra1];
  assign rd2 = rf_q[ra2];

endmodule

// File: rtl/alu_ctrl_stage.sv
// Sequencing stage in front of a combinational ALU: IDLE -> EXEC -> HOLD.
// Optional sticky status accumulator enabled by ALU_CTRL_STICKY_FLAGS_EN.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int N    = 3,
  parameter int REGS = 4,
  localparam int AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_opcode,
  input  logic [N-1:0]  alu_y,
  input  logic [4:0]    alu_status,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_rd,
  output logic [4:0]    out_status,
  output logic [4:0]    flags_sticky,
  input  logic          flags_clr
);

  fsm_state_t    state_reg, state_next;
  logic [3:0]    opcode_reg;
  logic [AW-1:0] rs1_reg, rs2_reg, rd_reg;
  logic [N-1:0]  a_hold_reg, b_hold_reg;
  logic [N-1:0]  out_data_reg;
  logic [AW-1:0] out_rd_reg;
  logic [4:0]    out_status_reg;
  logic [N-1:0]  rf_a, rf_b;
  logic          accept;
  logic          exec;

  assign exec     = (state_reg == FSM_EXEC);
  assign in_ready = (state_reg == FSM_IDLE) || ((state_reg == FSM_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FSM_IDLE: if (in_valid) state_next = FSM_EXEC;
      FSM_EXEC: state_next = FSM_HOLD;
      FSM_HOLD: if (out_ready) state_next = in_valid ? FSM_EXEC : FSM_IDLE;
      default:  state_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FSM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_reg <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      rd_reg     <= '0;
    end else if (accept) begin
      opcode_reg <= in_opcode;
      rs1_reg    <= in_rs1;
      rs2_reg    <= in_rs2;
      rd_reg     <= in_rd;
    end
  end

  alu_regfile #(
    .N    (N),
    .REGS (REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (rs1_reg),
    .ra2     (rs2_reg),
    .rd1     (rf_a),
    .rd2     (rf_b),
    .wb_en   (exec),
    .wb_addr (rd_reg),
    .wb_data (alu_y),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Operands are live only in EXEC; elsewhere the ALU sees the last values used.
  assign alu_a      = exec ? rf_a : a_hold_reg;
  assign alu_b      = exec ? rf_b : b_hold_reg;
  assign alu_opcode = opcode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_reg     <= '0;
      b_hold_reg     <= '0;
      out_data_reg   <= '0;
      out_rd_reg     <= '0;
      out_status_reg <= '0;
    end else if (exec) begin
      a_hold_reg     <= rf_a;
      b_hold_reg     <= rf_b;
      out_data_reg   <= alu_y;
      out_rd_reg     <= rd_reg;
      out_status_reg <= alu_status;
    end
  end

  assign out_valid  = (state_reg == FSM_HOLD);
  assign out_data   = out_data_reg;
  assign out_rd     = out_rd_reg;
  assign out_status = out_status_reg;

`ifdef ALU_CTRL_STICKY_FLAGS_EN
  logic [4:0] sticky_reg;

  // Clear takes priority over accumulating the current EXEC status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= '0;
    end else if (flags_clr) begin
      sticky_reg <= '0;
    end else if (exec) begin
      sticky_reg <= sticky_reg | alu_status;
    end
  end

  assign flags_sticky = sticky_reg;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign flags_sticky     = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: a bench-side ALU closes the loop,
// a transaction-level model predicts outputs, directed cases pin the model.
module tb_alu_ctrl_stage;
  import alu_pkg::*;

  localparam int N    = 3;
  localparam int REGS = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = '0;
  logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [N-1:0]  ld_data = '0;
  logic [N-1:0]  alu_a, alu_b;
  logic [3:0]    alu_opcode;
  logic [N-1:0]  alu_y;
  logic [4:0]    alu_status;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_rd;
  logic [4:0]    out_status;
  logic [4:0]    flags_sticky;
  logic          flags_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_ctrl_stage #(.N(N), .REGS(REGS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_y        (alu_y),
    .alu_status   (alu_status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_status   (out_status),
    .flags_sticky (flags_sticky),
    .flags_clr    (flags_clr)
  );

  always #5 clk = ~clk;

  // Bench-side ALU; returns {status, y} with status {P,V,N,Z,C}.
  function automatic logic [N+4:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] op);
    logic [N:0]   w;
    logic [N-1:0] y;
    logic         c, v;
    logic [4:0]   st;
    c = 1'b0;
    v = 1'b0;
    y = '0;
    case (op)
      4'd0: begin
        w = {1'b0, a} - {1'b0, b};
        y = w[N-1:0];
        c = w[N];
        v = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      4'd1: begin
        w = {1'b0, a} + {1'b0, b};
        y = w[N-1:0];
        c = w[N];
        v = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      4'd2:  y = a & b;
      4'd3:  y = a | b;
      4'd4:  y = a ^ b;
      4'd5:  y = ~a;
      4'd6:  y = a << 1;
      4'd7:  y = a >> 1;
      4'd8:  y = a + N'(1);
      4'd9:  y = a - N'(1);
      4'd10: y = a;
      4'd11: y = b;
      4'd12: y = '0;
      4'd13: y = '1;
      4'd14: y = a;
      default: y = N'(1);
    endcase
    st = {~^y, v, y[N-1] ^ v, (y == '0), c};
    if (op >= 4'd12) st = '0;
    return {st, y};
  endfunction

  assign {alu_status, alu_y} = alu_f(alu_a, alu_b, alu_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [N-1:0]  m_rf [REGS];
  bit            m_exec = 0;
  logic [3:0]    m_opc = '0;
  logic [AW-1:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  bit            m_res = 0;
  logic [N-1:0]  m_data = '0;
  logic [AW-1:0] m_out_rd = '0;
  logic [4:0]    m_st = '0;
  logic [4:0]    m_sticky = '0;

  task automatic model_step();
    bit            rdy, wb;
    logic [N+4:0]  r;
    logic [AW-1:0] wa;
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) m_rf[i] = '0;
      m_exec = 0; m_res = 0; m_data = '0; m_out_rd = '0; m_st = '0; m_sticky = '0;
      return;
    end
    rdy = !m_exec && (!m_res || out_ready);
    wb  = 0;
    wa  = '0;
    r   = '0;
    if (m_exec) begin
      r        = alu_f(m_rf[m_rs1], m_rf[m_rs2], m_opc);
      m_data   = r[N-1:0];
      m_st     = r[N+4:N];
      m_out_rd = m_rd;
      m_res    = 1;
      m_sticky = m_sticky | m_st;
      wb       = 1;
      wa       = m_rd;
      m_exec   = 0;
    end else if (m_res && out_ready) begin
      m_res = 0;
    end
    if (flags_clr) m_sticky = '0;
    if (in_valid && rdy) begin
      m_exec = 1; m_opc = in_opcode; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
    end
    if (ld_en && !(wb && ld_addr == wa)) m_rf[ld_addr] = ld_data;
    if (wb) m_rf[wa] = r[N-1:0];
  endtask

  initial begin
    for (int i = 0; i < REGS; i++) m_rf[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // One compare pass per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, m_res);
      chk("in_ready", in_ready, !m_exec && (!m_res || out_ready));
      if (m_res) begin
        chk("out_data", out_data, m_data);
        chk("out_rd", out_rd, m_out_rd);
        chk("out_status", out_status, m_st);
        if (out_ready)
          $display("txn rd=%0d data=%0h status=%b", out_rd, out_data, out_status);
      end
      if (m_exec) begin
        chk("alu_a", alu_a, m_rf[m_rs1]);
        chk("alu_b", alu_b, m_rf[m_rs2]);
        chk("alu_opcode", alu_opcode, m_opc);
      end
`ifdef ALU_CTRL_STICKY_FLAGS_EN
      chk("flags_sticky", flags_sticky, m_sticky);
`else
      chk("flags_sticky", flags_sticky, 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_opcode = op; in_rs1 = s1; in_rs2 = s2; in_rd = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("accept_timeout", ok, 1);
  endtask

  task automatic wait_result();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
      if (!ok) tick();
    end
    chk("result_timeout", ok, 1);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_status", out_status, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;

    // ADD 3+2 with exact latency
    load(2'd1, 3'd3);
    load(2'd2, 3'd2);
    issue(OP_ADD, 2'd1, 2'd2, 2'd3);
    @(negedge clk);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_alu_a", alu_a, 3);
    chk("exec_alu_b", alu_b, 2);
    chk("exec_alu_opcode", alu_opcode, 1);
    tick();
    @(negedge clk);
    chk("add_out_valid", out_valid, 1);
    chk("add_out_data", out_data, 3'b101);
    chk("add_out_status", out_status, 5'b11000);
    chk("add_out_rd", out_rd, 3);
    tick();

    // SUB to zero
    issue(OP_SUB, 2'd1, 2'd1, 2'd0);
    wait_result();
    chk("sub_out_data", out_data, 0);
    chk("sub_out_status", out_status, 5'b10010);
    tick();

    // Backpressure, then release with a new op waiting
    out_ready = 1'b0;
    issue(OP_ADD, 2'd1, 2'd1, 2'd0);
    wait_result();
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 3'b110);
      chk("bp_in_ready", in_ready, 0);
      tick();
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = OP_XOR; in_rs1 = 2'd1; in_rs2 = 2'd2; in_rd = 2'd0;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_exec_valid", out_valid, 0);
    chk("bp_next_exec_opcode", alu_opcode, 4);
    wait_result();
    chk("bp_xor_data", out_data, 3'b001);
    tick();

    // Writeback beats a same-address load
    issue(OP_ADD, 2'd1, 2'd2, 2'd3);
    load(2'd3, 3'd7);
    wait_result();
    chk("coll_out_data", out_data, 5);
    tick();
    issue(OP_SUB, 2'd3, 2'd2, 2'd1);
    wait_result();
    chk("coll_rf3_readback", out_data, 3);
    tick();

    // Reset during EXEC
    issue(OP_ADD, 2'd1, 2'd2, 2'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rexec_out_valid", out_valid, 0);
    chk("rexec_out_data", out_data, 0);
    chk("rexec_out_rd", out_rd, 0);
    chk("rexec_out_status", out_status, 0);
    chk("rexec_alu_b", alu_b, 0);
    chk("rexec_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rexec_release_in_ready", in_ready, 1);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2);
    wait_result();
    chk("rexec_rf_cleared", out_data, 0);
    chk("rexec_rf_status", out_status, 5'b10010);
    tick();

    // Sticky flags
    load(2'd1, 3'd3);
    load(2'd2, 3'd2);
    issue(OP_ADD, 2'd1, 2'd2, 2'd3);
    wait_result();
    tick();
    issue(OP_SUB, 2'd1, 2'd1, 2'd0);
    wait_result();
`ifdef ALU_CTRL_STICKY_FLAGS_EN
    chk("sticky_accum", flags_sticky, 5'b11010);
`else
    chk("sticky_tied", flags_sticky, 0);
`endif
    tick();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", flags_sticky, 0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_opcode = 4'($urandom_range(0, 15));
      in_rs1    = AW'($urandom_range(0, REGS - 1));
      in_rs2    = AW'($urandom_range(0, REGS - 1));
      in_rd     = AW'($urandom_range(0, REGS - 1));
      ld_en     = ($urandom_range(0, 9) < 3);
      ld_addr   = AW'($urandom_range(0, REGS - 1));
      ld_data   = N'($urandom_range(0, (1 << N) - 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flags_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0; ld_en = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Sequencing stage that sits directly upstream of the combinational ALU. It accepts register-addressed operations over a valid/ready handshake and drives the ALU's `A`, `B` and `Opcode` from a small internal register file. It captures the ALU's `Y` and 5-bit `status`, writes `Y` back to the destination register, and presents result plus status downstream over a second valid/ready handshake.

## Interface
Parameters:
- `N`, 3: data width; equals the ALU data width.
- `REGS`, 4: register-file depth; power of two, ≥2. `AW = $clog2(REGS)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  stage can accept an operation.
- `in_opcode`  in  4  ALU opcode, 0–15.
- `in_rs1`, `in_rs2`, `in_rd`  in  AW each  source A, source B, destination.
- `ld_en`  in  1  direct register load strobe.
- `ld_addr`  in  AW  load address.
- `ld_data`  in  N  load data.
- `alu_a`, `alu_b`  out  N each  to ALU `A`/`B`.
- `alu_opcode`  out  4  to ALU `Opcode`.
- `alu_y`  in  N  from ALU `Y`.
- `alu_status`  in  5  from ALU `status`: {parity, overflow, negative/less, zero, carry}.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  N  captured `Y`.
- `out_rd`  out  AW  destination written.
- `out_status`  out  5  captured status.
- `flags_sticky`  out  5  see Configuration.
- `flags_clr`  in  1  see Configuration.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, latch opcode, rs1, rs2 and rd into op registers; go to EXEC.
- EXEC (exactly one cycle):
  - `in_ready=0`.
  - `alu_a=rf[rs1]`, `alu_b=rf[rs2]` read combinationally.
  - `alu_opcode` = latched opcode.
  - At the clock edge: `out_data<=alu_y`, `out_status<=alu_status`, `out_rd<=rd`, `rf[rd]<=alu_y`; go to HOLD.
- HOLD:
  - `out_valid=1`.
  - If `out_ready=1`: `in_ready=1`. If `in_valid=1` as well, latch the new op and go to EXEC; otherwise go to IDLE.
  - If `out_ready=0`: stay in HOLD; `out_*` held stable.
- Outside EXEC, `alu_a`, `alu_b` and `alu_opcode` hold the last latched values. No X on the ALU inputs.
- Opcodes 12–15 produce ALU status 0. That value is passed through unchanged; writeback still occurs.
- Load port:
  - `ld_en` writes `rf[ld_addr]<=ld_data` in any state.
  - If writeback and load target the same address in the same cycle, writeback wins and the load is dropped.
  - A load to a different address proceeds in the same cycle.
- A load in the cycle before EXEC is visible to that EXEC, because the read happens during EXEC.
- All arithmetic is performed by the ALU. This stage does no width conversion; all data paths are N bits.

## Timing
- Accept at edge k → EXEC during cycle k+1 → `out_valid` high from edge k+2.
- Back-to-back throughput: one op per 2 cycles (HOLD→EXEC).
- Reset values:
  - state IDLE, all `rf` entries 0.
  - `out_valid`, `out_data`, `out_rd`, `out_status` = 0.
  - `alu_a`, `alu_b`, `alu_opcode` = 0.
  - `flags_sticky` = 0.
- Reset asserted in EXEC or HOLD aborts the op: no writeback, result lost, `in_ready=1` on the first cycle after deassertion.
- `in_ready` depends combinationally on `out_ready` in HOLD only. No other combinational in→out paths exist, apart from the ALU loop in EXEC.

## Configuration
- `ALU_CTRL_STICKY_FLAGS_EN` defined:
  - `flags_sticky` is a register. At every EXEC edge it updates to `flags_sticky | alu_status`.
  - `flags_clr=1` clears it at the next edge. If a clear and an EXEC OR occur in the same cycle, the clear wins.
- `ALU_CTRL_STICKY_FLAGS_EN` undefined: `flags_sticky` is tied to 0, `flags_clr` is ignored, and no register is inferred.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `OP_SUB=0` … `OP_ONE=15`.
  - Status bit indices `ST_C=0`, `ST_Z=1`, `ST_N=2`, `ST_V=3`, `ST_P=4`.
  - FSM state enum.
- One natural sub-module, `alu_regfile`: two combinational read ports and one write port with writeback-over-load priority.

## Test plan
- Load r1=3, r2=2; op ADD(1), rd=3, rs1=1, rs2=2 → `out_data`=3'b101, `out_status`=5'b11000, `rf[3]`=5, `out_valid` at accept+2.
- Op SUB(0), rs1=rs2=1, rd=0 → `out_data`=0, `out_status`=5'b10010.
- Hold `out_ready=0` for 3 cycles while in HOLD → `out_valid` stays 1, `out_*` stable, `in_ready=0`. Raise `out_ready` with `in_valid=1` → next op enters EXEC the following cycle.
- `ld_en` with `ld_addr`=3, `ld_data`=7 in the same cycle as EXEC writeback to rd=3 (Y=5) → `rf[3]`=5.
- Assert `rst_n=0` during EXEC → no writeback, all outputs 0, `in_ready=1` after release.
- With `ALU_CTRL_STICKY_FLAGS_EN`: ADD overflow, then SUB giving zero → `flags_sticky`=5'b11010. `flags_clr` → 0.
